// File: rtl/song_sequencer_if.sv
// Button inputs and play-status outputs shared between the song sequencer and its consumers.
interface song_sequencer_if;
  logic       start_btn;
  logic       pause_btn;
  logic [2:0] state;
  logic       beat_tick;
  logic [5:0] beat_idx;
  logic [3:0] countin_left;
  logic       playing;
  logic       song_done;

  modport master (
    output start_btn, pause_btn,
    input  state, beat_tick, beat_idx, countin_left, playing, song_done
  );

  modport slave (
    input  start_btn, pause_btn,
    output state, beat_tick, beat_idx, countin_left, playing, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song play controller: owns the beat timebase and walks IDLE -> COUNTIN -> PLAY (-> PAUSE) -> DONE.
// Define PAUSE_EN to enable the pause button and the PAUSE state.
module song_sequencer #(
  parameter int SONG_BEATS    = 41,
  parameter int COUNTIN_BEATS = 4,
  parameter int BEAT_DIV      = 10_000_000
) (
  input logic              clk,
  input logic              n_rst,
  song_sequencer_if.slave  bus
);

  localparam int DIV_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(BEAT_DIV - 1);
  localparam logic [5:0]       LAST_BEAT = 6'(SONG_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNTIN = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_wrap;
  logic [5:0]       beat_idx_q, beat_idx_d;
  logic [3:0]       countin_q, countin_d;
  logic             song_done_q;
  logic             start_prev;
  logic             start_press;
  logic             pause_press;
  logic             tick;

  assign start_press = bus.start_btn & ~start_prev;

`ifdef PAUSE_EN
  logic pause_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pause_prev <= 1'b0;
    else        pause_prev <= bus.pause_btn;
  end

  assign pause_press = bus.pause_btn & ~pause_prev;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
  assign pause_press  = 1'b0;
`endif

  assign tick     = ((state_q == COUNTIN) || (state_q == PLAY)) && (div_q == DIV_MAX);
  assign div_wrap = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      beat_idx_q  <= '0;
      countin_q   <= '0;
      song_done_q <= 1'b0;
      start_prev  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      beat_idx_q  <= beat_idx_d;
      countin_q   <= countin_d;
      song_done_q <= (state_q != DONE) && (state_d == DONE);
      start_prev  <= bus.start_btn;
    end
  end

  // A tick in PLAY is handled before a coincident pause press; the final beat
  // goes to DONE and drops the pause. A pause without a tick freezes div.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    beat_idx_d = beat_idx_q;
    countin_d  = countin_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start_press) begin
          state_d    = COUNTIN;
          countin_d  = 4'(COUNTIN_BEATS);
          beat_idx_d = '0;
        end
      end
      COUNTIN: begin
        div_d = div_wrap;
        if (tick) begin
          if (countin_q == 4'd1) begin
            state_d    = PLAY;
            countin_d  = '0;
            beat_idx_d = '0;
          end else begin
            countin_d = countin_q - 4'd1;
          end
        end
      end
      PLAY: begin
        div_d = div_wrap;
        if (tick) begin
          if (beat_idx_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_idx_d = beat_idx_q + 6'd1;
            if (pause_press) state_d = PAUSE;
          end
        end else if (pause_press) begin
          state_d = PAUSE;
          div_d   = div_q;
        end
      end
      PAUSE: begin
        if (start_press) begin
          state_d    = IDLE;
          beat_idx_d = '0;
          div_d      = '0;
        end else if (pause_press) begin
          state_d = PLAY;
        end
      end
      DONE: begin
        div_d = '0;
        if (start_press) begin
          state_d    = IDLE;
          beat_idx_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        div_d      = '0;
        beat_idx_d = '0;
        countin_d  = '0;
      end
    endcase
  end

  always_comb begin
    bus.state        = state_q;
    bus.beat_tick    = tick;
    bus.beat_idx     = beat_idx_q;
    bus.countin_left = countin_q;
    bus.playing      = (state_q == PLAY);
    bus.song_done    = song_done_q;
  end

endmodule
